itcm_rsp: RTL
=============

Name: itcm_rsp

Overview:
- Instruction tightly-coupled memory responder; the memory-side end of the frontend instruction fetch read channel.
- Accepts a fetch address every cycle with no address-ready signal. Returns one DW-bit word after a fixed latency and holds it until the fetch unit takes it.
- A new request always aborts any read still in flight or waiting.
- Includes a byte-strobed preload/debug write port for filling the array.

Parameters:
- DW, 64, data width in bits. Must be a power of two, 32 or more.
- AW, 14, log2 of array depth in words.
- BASE, 64'h80000000, byte address of word 0.
- LATENCY, 1, cycles from address acceptance to RVALID. Legal range 1..4.

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset
- S_ITCM_ARADDR  in  64  fetch byte address
- S_ITCM_ARVALID  in  1  fetch request; always accepted
- S_ITCM_RVALID  out  1  response valid
- S_ITCM_RREADY  in  1  fetch unit consumes response
- S_ITCM_RDATA  out  DW  response word
- S_ITCM_RERR  out  1  response address out of range
- W_EN  in  1  preload write enable
- W_ADDR  in  64  preload byte address
- W_DATA  in  DW  preload data
- W_STRB  in  DW/8  byte enables

Behaviour:
- Clock and reset: reset RSTn, asynchronous, active-low; clock CLK.
- Reset values:
  - state = IDLE; counter = 0.
  - S_ITCM_RVALID = 0, S_ITCM_RDATA = 0, S_ITCM_RERR = 0.
  - Array contents are not reset.
- Address decode:
  - off = ADDR - BASE, in 64-bit modulo arithmetic.
  - index = off[AW+log2(DW/8)-1 : log2(DW/8)]. Low log2(DW/8) bits are ignored, so misaligned addresses read the containing word.
  - In range iff off < 2^AW * DW/8.
- State IDLE:
  - RVALID = 0.
  - ARVALID=1: accept. Go to BUSY with cnt = LATENCY-1, or straight to RESP if LATENCY = 1.
- State BUSY:
  - RVALID = 0; RREADY is ignored.
  - cnt decrements each cycle; at 0, go to RESP.
  - ARVALID=1: abort the old read, re-accept the new address, reload cnt.
- State RESP:
  - RVALID = 1; RDATA and RERR are held stable while RREADY = 0 and ARVALID = 0.
  - RREADY=1, ARVALID=0: response consumed; go to IDLE; RVALID = 0 next cycle.
  - RREADY=1, ARVALID=1: consume and accept the new request in the same cycle.
    - LATENCY = 1: stay in RESP with the new data next cycle (back-to-back, one word per cycle).
    - Otherwise: go to BUSY.
  - RREADY=0, ARVALID=1: the old response is dropped, never delivered; the new request is accepted.
- Acceptance edge = rising CLK where ARVALID = 1.
  - Array word is sampled at the acceptance edge and carried through a LATENCY-deep data/err pipeline.
  - Out-of-range request: RDATA = 0, RERR = 1.
- Total latency: accept at edge T gives RVALID = 1 after edge T+LATENCY-1, i.e. visible in cycle T+LATENCY, with no abort in between.
- Preload write:
  - W_EN=1 writes W_DATA bytes where W_STRB = 1, at the rising edge.
  - Out-of-range writes are ignored.
  - Write and read accepted at the same edge, same index: read returns the old data (read-before-write).
- A reset asserted mid-read or mid-response returns all outputs to reset values immediately. No response is produced after reset release until a new ARVALID.
- No combinational path from ARVALID or RREADY to any output. All outputs are registered.

Test Plan:
- Basic read, LATENCY=1:
  - Preload word 3 = 64'h1122334455667788.
  - ARVALID at 0x80000018 for one cycle → RVALID=1 next cycle with that data, RERR=0.
  - Held across 3 cycles of RREADY=0; drops the cycle after RREADY=1.
- Streaming:
  - ARVALID and RREADY held high, addresses 0x80000000, 0x80000008, 0x80000010.
  - Expect words 0, 1, 2 on consecutive cycles, RVALID continuously 1.
- Abort:
  - LATENCY=3: request A, then request B two cycles later → only B's data appears, 3 cycles after B. No RVALID pulse for A.
  - LATENCY=1, RESP with RREADY=0, new ARVALID: RDATA switches to the new word; the old word is never consumed.
- Range and alignment:
  - 0x7FFFFFF8 → RDATA=0, RERR=1.
  - 0x80000000 + 2^14*8 → RERR=1.
  - 0x8000000D → returns word 1, RERR=0.
- Write strobe and collision:
  - W_STRB=8'h0F to word 5 with data 64'hAAAAAAAA_BBBBBBBB over 64'h0 → reads 64'h00000000_BBBBBBBB.
  - Read of word 5 accepted at the same edge as the write returns the prior value.
- Reset mid-operation: RSTn low while in RESP → RVALID=0 and RDATA=0 immediately. After release, RVALID stays 0 until the next ARVALID.

Source files
------------

// File: rtl/itcm_rsp.sv
// Instruction TCM responder: the memory end of the instruction fetch read
// channel. A fetch address is taken on every cycle where ARVALID is high.
// One word comes back LATENCY cycles later and is held until RREADY. A new
// request always aborts whatever read is still pending. A byte-strobed
// write port fills the array for preload and debug.
module itcm_rsp #(
  parameter int          DW      = 64,
  parameter int          AW      = 14,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 1
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [63:0]     S_ITCM_ARADDR,
  input  logic            S_ITCM_ARVALID,
  output logic            S_ITCM_RVALID,
  input  logic            S_ITCM_RREADY,
  output logic [DW-1:0]   S_ITCM_RDATA,
  output logic            S_ITCM_RERR,
  input  logic            W_EN,
  input  logic [63:0]     W_ADDR,
  input  logic [DW-1:0]   W_DATA,
  input  logic [DW/8-1:0] W_STRB
);

  localparam int          NB        = DW / 8;
  localparam int          OFFB      = $clog2(NB);
  localparam int          DEPTH     = 1 << AW;
  localparam logic [63:0] SPAN      = 64'd1 << (AW + OFFB);
  localparam logic [2:0]  CNT_LOAD  = 3'(LATENCY - 1);
  localparam bit          ONE_CYCLE = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [DW-1:0] r_mem [DEPTH];

  state_t        r_state;
  state_t        w_nextState;
  logic [2:0]    r_cnt;
  logic [2:0]    w_nextCnt;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic          r_rerr;
  logic [DW-1:0] r_capData;
  logic          r_capErr;

  logic [63:0]   w_rdOff;
  logic          w_rdInRange;
  logic [AW-1:0] w_rdIdx;
  logic [DW-1:0] w_rdWord;
  logic [63:0]   w_wrOff;
  logic          w_wrInRange;
  logic [AW-1:0] w_wrIdx;

  // The offset from BASE wraps modulo 2^64, so addresses below BASE become
  // huge offsets and fall out of range. The low byte-lane bits are dropped,
  // which makes misaligned addresses read the word that contains them.
  assign w_rdOff     = S_ITCM_ARADDR - BASE;
  assign w_rdInRange = (w_rdOff < SPAN);
  assign w_rdIdx     = w_rdOff[AW+OFFB-1:OFFB];
  assign w_rdWord    = w_rdInRange ? r_mem[w_rdIdx] : '0;

  assign w_wrOff     = W_ADDR - BASE;
  assign w_wrInRange = (w_wrOff < SPAN);
  assign w_wrIdx     = w_wrOff[AW+OFFB-1:OFFB];

  assign S_ITCM_RVALID = r_rvalid;
  assign S_ITCM_RDATA  = r_rdata;
  assign S_ITCM_RERR   = r_rerr;

  // Preload writes update only the enabled byte lanes. The array is not reset.
  always_ff @(posedge CLK) begin
    if (W_EN && w_wrInRange) begin
      for (int b = 0; b < NB; b++) begin
        if (W_STRB[b]) begin
          r_mem[w_wrIdx][b*8 +: 8] <= W_DATA[b*8 +: 8];
        end
      end
    end
  end

  // Next-state logic. A request always wins and restarts the latency count.
  // Otherwise BUSY counts down to RESP, and RESP waits for RREADY.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (S_ITCM_ARVALID) begin
      w_nextCnt   = CNT_LOAD;
      w_nextState = ONE_CYCLE ? RESP : BUSY;
    end else begin
      case (r_state)
        BUSY: begin
          if (r_cnt == 3'd1) begin
            w_nextState = RESP;
            w_nextCnt   = 3'd0;
          end else begin
            w_nextCnt = r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (S_ITCM_RREADY) begin
            w_nextState = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter and RVALID registers. RVALID is registered from the next
  // state, so no input reaches an output combinationally.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_cnt    <= w_nextCnt;
      r_rvalid <= (w_nextState == RESP);
    end
  end

  // The word is sampled at the acceptance edge, before any write on that
  // same edge lands, so a colliding write is not seen. The response
  // registers change only when a response is presented. They are loaded
  // directly at acceptance for single-cycle latency, or from the capture
  // register when the countdown expires.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_capData <= '0;
      r_capErr  <= 1'b0;
      r_rdata   <= '0;
      r_rerr    <= 1'b0;
    end else begin
      if (S_ITCM_ARVALID) begin
        r_capData <= w_rdWord;
        r_capErr  <= !w_rdInRange;
      end
      if (S_ITCM_ARVALID && ONE_CYCLE) begin
        r_rdata <= w_rdWord;
        r_rerr  <= !w_rdInRange;
      end else if (!S_ITCM_ARVALID && r_state == BUSY && r_cnt == 3'd1) begin
        r_rdata <= r_capData;
        r_rerr  <= r_capErr;
      end
    end
  end

endmodule
